// File: rtl/riscv_pkg.sv
// Shared core types: register-file geometry, arbiter state
// encoding and the long-latency result FIFO entry.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } lu_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Long-latency result FIFO with wrap-bit pointers and a
// per-slot live-bit clear used to squash overwritten results.
module result_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  lu_entry_t                  push_entry,
  input  logic                       pop,
  input  logic [DEPTH-1:0]           clr,
  output lu_entry_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]           occ,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  lu_entry_t [DEPTH-1:0] mem;
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] cnt;
  logic        do_push;
  logic        do_pop;

  assign cnt     = wptr - rptr;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = rptr[AW-1:0];
  assign entries = mem;

  // A slot is occupied when its distance from head is below the count.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++)
      occ[i] = {1'b0, AW'(i) - head} < cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (clr[i]) mem[i].live <= 1'b0;
      if (do_push) mem[wptr[AW-1:0]] <= push_entry;
      wptr <= wptr + (AW+1)'(do_push);
      rptr <= rptr + (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and the
// long-latency unit; a starvation FSM forces a slot for the FIFO.
module rf_write_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RDW,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
  output logic                  wb_stall,
  output logic [NUM_REGS-1:0]   rd_pending
);

  localparam int AW = $clog2(DEPTH);

  arb_state_e state;
  arb_state_e state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  lu_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0]      occ;
  logic [DEPTH-1:0]      clr;
  logic [AW-1:0]         head;
  logic                  full;
  logic                  empty;
  lu_entry_t             head_e;
  lu_entry_t             push_e;

  logic pipe_req;
  logic pop;
  logic push_store;

  logic                  we_n;
  logic [REG_ADDR_W-1:0] rd_n;
  logic [XLEN-1:0]       wd_n;
  logic [NUM_REGS-1:0]   pending_n;

  assign lu_ready   = !full;
  assign push_store = lu_valid && !full && lu_rd != '0;
  assign pipe_req   = RegWriteW && RDW != '0 && !wb_stall;
  assign pop        = !pipe_req && !empty;
  assign head_e     = ent[head];
  assign push_e     = '{live: 1'b1, rd: lu_rd, data: lu_data};

  result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_store),
    .push_entry(push_e),
    .pop       (pop),
    .clr       (clr),
    .entries   (ent),
    .occ       (occ),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Older queued results to the same rd are dead once writeback wins.
  always_comb begin
    clr = '0;
    for (int i = 0; i < DEPTH; i++)
      clr[i] = pipe_req && occ[i] && ent[i].live && ent[i].rd == RDW;
  end

  always_comb begin
    pending_n = '0;
    for (int i = 0; i < DEPTH; i++)
      if (occ[i] && ent[i].live && !clr[i] && !(pop && AW'(i) == head))
        pending_n[ent[i].rd] = 1'b1;
    if (push_store) pending_n[lu_rd] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_comb begin
    we_n = 1'b0;
    rd_n = rf_rd;
    wd_n = rf_wd;
    unique case (1'b1)
      pipe_req: begin
        we_n = 1'b1;
        rd_n = RDW;
        wd_n = ResultW;
      end
      pop: begin
        if (head_e.live) begin
          we_n = 1'b1;
          rd_n = head_e.rd;
          wd_n = head_e.data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ARB_NORMAL: begin
        if (empty || pop) begin
          cnt_n = '0;
        end else if (cnt == CW'(STARVE_LIMIT - 1)) begin
          state_n = ARB_FORCE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ARB_FORCE: begin
        state_n = ARB_NORMAL;
        cnt_n   = '0;
      end
      default: begin
        state_n = ARB_NORMAL;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_NORMAL;
      cnt        <= '0;
      wb_stall   <= 1'b0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wd      <= '0;
      rd_pending <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wb_stall   <= state_n == ARB_FORCE;
      rf_we      <= we_n;
      rf_rd      <= rd_n;
      rf_wd      <= wd_n;
      rd_pending <= pending_n;
    end
  end

endmodule
